// File: rtl/tx_sched.sv
// tx_sched: round-robin scheduler that shares one packet encoder between N_REQ sources
module tx_sched #(
   parameter int N_REQ  = 4,
   parameter int N_PKT  = 8,
   parameter int REPEAT = 2,
   parameter int GAP_CT = 1000,
   parameter int ACK_TO = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid_i,
   input  logic [N_REQ*N_PKT-1:0]   req_data_i,
   output logic [N_REQ-1:0]         req_ready_o,
   output logic [N_PKT-1:0]         enc_data_o,
   output logic                     enc_start_o,
   input  logic                     enc_avail_i,
   output logic                     tx_done_o,
   output logic [$clog2(N_REQ)-1:0] tx_id_o,
   output logic                     tx_err_o,
   output logic                     busy_o
);
   localparam int IW = $clog2(N_REQ);
   localparam int RW = REPEAT > 1 ? $clog2(REPEAT) : 1;
   localparam int GW = GAP_CT > 1 ? $clog2(GAP_CT) : 1;
   localparam int AW = ACK_TO > 1 ? $clog2(ACK_TO) : 1;

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACK, BUSY, GAP} state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    rr_q, rr_d, id_q, id_d, gnt, j;
   logic [N_PKT-1:0] data_q, data_d, sel;
   logic [RW-1:0]    rep_q, rep_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [AW-1:0]    ack_q, ack_d;
   logic             fin_q, fin_d, err_q, err_d;
   logic             accept, timeout, done, gap_end;

   // grant = first valid source after rr_q (wrapping); descending scan lets the nearest one win
   always_comb begin
      gnt = rr_q;
      j   = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         j = IW'((int'(rr_q) + k) % N_REQ);
         if (req_valid_i[j]) gnt = j;
      end
   end

   // payload mux for the granted source
   always_comb begin
      sel = '0;
      for (int k = 0; k < N_REQ; k++)
         if (IW'(k) == gnt) sel = req_data_i[k*N_PKT +: N_PKT];
   end

   assign accept  = state_q == IDLE && |req_valid_i && enc_avail_i;
   assign timeout = state_q == WAIT_ACK && enc_avail_i && ack_q == AW'(ACK_TO - 1);
   assign done    = timeout || (state_q == BUSY && enc_avail_i && rep_q == RW'(REPEAT - 1));
   assign gap_end = GAP_CT == 0 || gap_q == GW'(GAP_CT - 1);

   assign req_ready_o = (accept && rst_n) ? N_REQ'(1) << gnt : '0;
   assign enc_start_o = state_q == LAUNCH && enc_avail_i;
   assign enc_data_o  = data_q;
   assign tx_id_o     = id_q;
   assign tx_done_o   = done;
   assign tx_err_o    = done ? timeout : err_q;
   assign busy_o      = state_q != IDLE;

   // next-state logic; counters run only in their own state and clear elsewhere
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      id_d    = id_q;
      data_d  = data_q;
      rep_d   = rep_q;
      fin_d   = fin_q;
      err_d   = done ? timeout : err_q;
      gap_d   = state_q == GAP ? gap_q + 1'b1 : '0;
      ack_d   = state_q == WAIT_ACK ? ack_q + 1'b1 : '0;
      case (state_q)
         IDLE: if (accept) begin
            state_d = LAUNCH;
            data_d  = sel;
            id_d    = gnt;
            rr_d    = gnt;
            rep_d   = '0;
            fin_d   = 1'b0;
         end
         LAUNCH: state_d = enc_avail_i ? WAIT_ACK : LAUNCH;
         WAIT_ACK: begin
            state_d = !enc_avail_i ? BUSY : timeout ? GAP : WAIT_ACK;
            fin_d   = fin_q | timeout;
         end
         BUSY: if (enc_avail_i) begin
            state_d = GAP;
            fin_d   = done;
            rep_d   = done ? rep_q : rep_q + 1'b1;
         end
         GAP: state_d = !gap_end ? GAP : fin_q ? IDLE : LAUNCH;
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rr_q    <= IW'(N_REQ - 1);
         id_q    <= '0;
         data_q  <= '0;
         rep_q   <= '0;
         gap_q   <= '0;
         ack_q   <= '0;
         fin_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         data_q  <= data_d;
         rep_q   <= rep_d;
         gap_q   <= gap_d;
         ack_q   <= ack_d;
         fin_q   <= fin_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: doc/tx_sched.md
Name: tx_sched

Overview:
Transmit scheduler that shares the single packet Encoder between N_REQ independent packet sources.
- Arbitrates round-robin among requesters and captures the winner's N_PKT-bit payload.
- Launches the Encoder REPEAT times per packet, inserting a GAP_CT-cycle idle gap after every transmission.
- Reports completion, the source ID and acknowledge-timeout errors.
- Sits between the board-level control logic and the Encoder, replacing the manual start handshake.

Parameters:
N_REQ, 4, number of requesters (≥2)
N_PKT, 8, payload width; must match the Encoder's N_PKT
REPEAT, 2, transmissions per accepted packet (≥1)
GAP_CT, 1000, idle cycles after each transmission (0 = no gap)
ACK_TO, 8, cycles allowed for enc_avail to fall after enc_start (≥1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-source packet pending; held until accepted
req_data  in  N_REQ*N_PKT  payloads; source i occupies bits [i*N_PKT +: N_PKT]
req_ready  out  N_REQ  one-hot, 1-cycle accept pulse to the granted source
enc_data  out  N_PKT  payload to the Encoder, registered
enc_start  out  1  1-cycle launch pulse to the Encoder
enc_avail  in  1  Encoder idle/ready
tx_done  out  1  1-cycle pulse when all REPEAT transmissions finish or an error aborts
tx_id  out  $clog2(N_REQ)  source of the current/last packet
tx_err  out  1  valid with tx_done: set when the ACK timeout fired
busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0. State = IDLE, rr_ptr = N_REQ-1, rep_cnt = 0, counters = 0.
- Reset mid-operation: returns to IDLE at once. enc_start drops asynchronously. The in-flight packet is discarded and tx_done is not pulsed.

State machine: IDLE, LAUNCH, WAIT_ACK, BUSY, GAP.
- IDLE:
  - Waits until |req_valid and enc_avail are both high.
  - Grant g = first set bit of req_valid, searching from rr_ptr+1 upward with wrap to 0.
  - Same cycle: req_ready[g] = 1 (combinational from state and inputs).
  - Next edge: enc_data <= req_data[g], tx_id <= g, rr_ptr <= g, rep_cnt <= 0, go to LAUNCH.
- LAUNCH:
  - With enc_avail high: enc_start = 1 for exactly this cycle, ack counter cleared, go to WAIT_ACK.
  - With enc_avail low: wait with enc_start = 0.
- WAIT_ACK:
  - enc_avail low: go to BUSY.
  - Otherwise the ack counter increments. When it reaches ACK_TO with enc_avail still high: pulse tx_done with tx_err = 1, go to GAP. The abort skips the remaining repeats.
- BUSY:
  - Waits for enc_avail to rise; that is the end of the transmission.
  - On the rise: if rep_cnt == REPEAT-1, pulse tx_done with tx_err = 0 and set the done flag; otherwise rep_cnt++. Either way go to GAP.
- GAP:
  - Counts GAP_CT cycles.
  - On exit: done flag set → IDLE; otherwise → LAUNCH.
  - With GAP_CT = 0, GAP lasts exactly 1 cycle.
- tx_err is held until the next tx_done.
- req_valid changing while not in IDLE is ignored; pending requests wait.
- Only one req_ready pulse per accepted packet; never more than one bit set.
- enc_data is stable from capture until the next IDLE acceptance.
- Fairness: with all sources valid, grants rotate 0,1,2,3,0,… starting from reset (rr_ptr = N_REQ-1).
- Counter widths: $clog2 of max value+1, saturating logic not required.

Test Plan:
1. Single request: req_valid = 0010, data 0xA5, Encoder model drops avail 1 cycle after start and holds busy 20 cycles, REPEAT = 2, GAP_CT = 3.
   - Expect req_ready = 0010 for 1 cycle.
   - Expect two enc_start pulses, each with enc_data = 0xA5.
   - Expect tx_done once, with tx_id = 1 and tx_err = 0.
   - Gap between the avail rise and the second start is 3 GAP cycles plus 1 LAUNCH cycle.
2. Round-robin: req_valid = 1111 held continuously. Expect grant order 0,1,2,3,0. Each req_ready comes only after the prior tx_done and GAP.
3. ACK timeout: Encoder model never drops enc_avail, ACK_TO = 8.
   - Expect tx_done with tx_err = 1 eight cycles after enc_start.
   - Expect a single enc_start (no repeat), then return to IDLE after GAP.
4. Encoder not ready: enc_avail low while req_valid = 0001.
   - Expect no req_ready and no enc_start.
   - When avail rises: accept, with the start pulse one cycle later.
5. Reset mid-BUSY: assert rst_n = 0 during the first transmission.
   - Expect all outputs 0 immediately and no tx_done.
   - After release, the next grant goes to source 0.
6. Late request: req_valid = 1000 raised during GAP of source 0's packet. Expect it accepted in the first IDLE cycle with tx_id = 3.
